// File: rtl/nexi_uart_tx_feeder.sv
// Byte FIFO plus command_send/done_ack sequencer feeding nexi_uart_tx.
// Optional handshake timeout: define NEXI_UART_TX_FEEDER_TIMEOUT_EN.
module nexi_uart_tx_feeder #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int TO_W           = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk_1x_bps,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              clr_flags,
    output logic              busy,
    output logic              tx_command_send,
    output logic [7:0]        tx_data,
    input  logic              tx_done_ack,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'b001,
        S_REQ       = 3'b010,
        S_WAIT_DONE = 3'b100
    } state_t;

    generate
        if (DEPTH < 2 || DEPTH != (2 ** ADDR_W) || TIMEOUT_CYCLES >= (2 ** TO_W)) begin : g_bad_cfg
            $error("nexi_uart_tx_feeder: inconsistent DEPTH/ADDR_W/TO_W/TIMEOUT_CYCLES");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [7:0]       mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic             push, pop, timeout_hit;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push       = wr_en && !full;
    assign pop        = (state == S_IDLE) && !empty && tx_done_ack;
    assign wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, pop};
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk_1x_bps) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            full   <= (level_nxt == (ADDR_W+1)'(DEPTH));
            empty  <= (level_nxt == '0);
        end
    end

    always_ff @(posedge clk_1x_bps) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk_1x_bps) begin
        if (rst) begin
            tx_data  <= 8'h00;
            overflow <= 1'b0;
            state    <= S_IDLE;
        end else begin
            if (pop) tx_data <= mem[rd_ptr[ADDR_W-1:0]];
            overflow <= (wr_en && full) || (overflow && !clr_flags);
            state    <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (pop)          state_nxt = S_REQ;
            S_REQ:       if (!tx_done_ack) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_done_ack)  state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
        if (timeout_hit) state_nxt = S_IDLE;
    end

    assign tx_command_send = (state == S_REQ);
    assign busy            = (state != S_IDLE);

`ifdef NEXI_UART_TX_FEEDER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in the current busy phase.
    assign timeout_hit = (state != S_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_1x_bps) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_nxt != state)  to_cnt <= '0;
            else if (state != S_IDLE) to_cnt <= to_cnt + 1'b1;
            err_q <= timeout_hit || (err_q && !clr_flags);
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nexi_uart_tx_feeder.sv
// Self-checking bench for nexi_uart_tx_feeder: vector table, directed corners, random vs queue model.
module tb_nexi_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 20;

    logic          clk_1x_bps = 1'b0;
    logic          rst, wr_en, clr_flags, tx_done_ack;
    logic [7:0]    wr_data;
    logic          full, empty, overflow, busy, tx_command_send, err_timeout;
    logic [AW:0]   level;
    logic [7:0]    tx_data;

    always #5 clk_1x_bps = ~clk_1x_bps;

    nexi_uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(AW), .TO_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk_1x_bps(clk_1x_bps), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .clr_flags(clr_flags), .busy(busy), .tx_command_send(tx_command_send),
        .tx_data(tx_data), .tx_done_ack(tx_done_ack), .err_timeout(err_timeout)
    );

    int nvec = 0, nerr = 0;

    // reference model: byte queue plus handshake phase (0 idle, 1 request, 2 wait done)
    byte unsigned mq[$];
    int           m_phase, m_to;
    logic [7:0]   m_data;
    bit           m_ovf, m_err;

    // transmitter model driving done_ack
    bit txm_en, txm_rand, txm_ack;
    int txm_cnt, txm_hold, txm_low;

    byte unsigned obs_data[$];
    int           obs_lvl[$];
    bit           prev_cmd;

    typedef struct {
        bit         rst, we, ack;
        logic [7:0] wd;
        int         lvl;
        bit         cmd, bsy;
        logic [7:0] data;
    } vec_t;
    vec_t tbl[10];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic model_update();
        bit full_m, pop, hit;
        int np;
        if (rst) begin
            mq.delete(); m_phase = 0; m_data = 8'h00; m_ovf = 0; m_err = 0; m_to = 0;
            return;
        end
        full_m = (mq.size() == DEPTH);
        pop    = (m_phase == 0) && (mq.size() != 0) && tx_done_ack;
        np     = m_phase;
        if (pop) np = 1;
        else if (m_phase == 1 && !tx_done_ack) np = 2;
        else if (m_phase == 2 && tx_done_ack) np = 0;
        hit = 1'b0;
`ifdef NEXI_UART_TX_FEEDER_TIMEOUT_EN
        hit = (m_phase != 0) && (m_to == TO - 1);
`endif
        if (hit) np = 0;
        if (np != m_phase) m_to = 0;
        else if (m_phase != 0) m_to++;
        m_err = hit || (m_err && !clr_flags);
        m_ovf = (wr_en && full_m) || (m_ovf && !clr_flags);
        if (pop) m_data = mq.pop_front();
        if (wr_en && !full_m) mq.push_back(wr_data);
        m_phase = np;
    endtask

    task automatic tick();
        logic [18:0] got, exp;
        if (txm_en) begin
            if (txm_rand && txm_cnt == 0) begin
                txm_hold = $urandom_range(1, 4);
                txm_low  = $urandom_range(1, 12);
            end
            if (txm_ack && m_phase == 1) begin
                txm_cnt++;
                if (txm_cnt >= txm_hold) begin txm_ack = 1'b0; txm_cnt = 0; end
            end else if (!txm_ack) begin
                txm_cnt++;
                if (txm_cnt >= txm_low) begin txm_ack = 1'b1; txm_cnt = 0; end
            end
            tx_done_ack = txm_ack;
        end
        @(posedge clk_1x_bps);
        model_update();
        if (rst) begin txm_ack = 1'b1; txm_cnt = 0; end
        #1;
        got = {full, empty, level, overflow, busy, tx_command_send, tx_data, err_timeout};
        exp = {mq.size() == DEPTH, mq.size() == 0, 5'(mq.size()), m_ovf, m_phase != 0,
               m_phase == 1, m_data, m_err};
        chk("cycle_model", 32'(got), 32'(exp));
        if (tx_command_send && !prev_cmd) begin
            obs_data.push_back(tx_data);
            obs_lvl.push_back(int'(level));
        end
        prev_cmd = tx_command_send;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic txm_start(input int hold, input int low);
        txm_en = 1'b1; txm_rand = 1'b0; txm_ack = 1'b1; txm_cnt = 0;
        txm_hold = hold; txm_low = low;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_flags = 1'b0; tx_done_ack = 1'b1;
        txm_en = 1'b0; txm_rand = 1'b0; txm_ack = 1'b1; txm_cnt = 0; txm_hold = 2; txm_low = 10;
        m_phase = 0; m_to = 0; m_data = 8'h00; m_ovf = 0; m_err = 0; prev_cmd = 1'b0;

        //          rst  we   ack  wd     lvl cmd bsy data
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h33};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h33};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 8'h33};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 8'hcc, 1, 1'b0, 1'b1, 8'h33};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h33};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'hcc};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 8'hcc};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'hcc};

        // reset state
        tick();
        rst = 1'b0;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_flags", 32'({overflow, err_timeout, busy, tx_command_send}), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; wr_en = tbl[i].we; wr_data = tbl[i].wd; tx_done_ack = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d", i),
                {13'd0, 5'(level), tx_command_send, busy, tx_data, 5'd0},
                {13'd0, 5'(tbl[i].lvl), tbl[i].cmd, tbl[i].bsy, tbl[i].data, 5'd0});
        end
        rst = 1'b0; wr_en = 1'b0;

        // single byte with responsive transmitter: latency and return to idle
        do_reset();
        txm_start(2, 10);
        wr_en = 1'b1; wr_data = 8'h33; tick(); wr_en = 1'b0;
        chk("lat_n_cmd", 32'(tx_command_send), 32'd0);
        tick();
        chk("lat_n1_cmd", 32'(tx_command_send), 32'd1);
        chk("lat_n1_data", 32'(tx_data), 32'h33);
        for (int i = 0; i < 20; i++) tick();
        chk("single_idle", 32'({busy, empty}), 32'b01);

        // three bytes queued, then drained in order
        do_reset();
        txm_en = 1'b0; tx_done_ack = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h33; tick();
        wr_data = 8'hcc; tick();
        wr_data = 8'h11; tick();
        wr_en = 1'b0;
        chk("b2b_level3", 32'(level), 32'd3);
        obs_data.delete(); obs_lvl.delete();
        txm_start(2, 10);
        for (int i = 0; i < 60; i++) tick();
        chk("b2b_count", 32'(obs_data.size()), 32'd3);
        if (obs_data.size() == 3) begin
            chk("b2b_d0", 32'(obs_data[0]), 32'h33);
            chk("b2b_d1", 32'(obs_data[1]), 32'hcc);
            chk("b2b_d2", 32'(obs_data[2]), 32'h11);
            chk("b2b_l0", 32'(obs_lvl[0]), 32'd2);
            chk("b2b_l1", 32'(obs_lvl[1]), 32'd1);
            chk("b2b_l2", 32'(obs_lvl[2]), 32'd0);
        end

        // stalled transmitter: fill, overflow, clear, write-while-full with pop
        do_reset();
        txm_en = 1'b0; tx_done_ack = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick();
            if (i == 16) chk("fill_full16", 32'({full, 5'(level), overflow}), 32'({1'b1, 5'd16, 1'b0}));
        end
        wr_en = 1'b0;
        chk("ovf_set", 32'({overflow, 5'(level)}), 32'({1'b1, 5'd16}));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        tx_done_ack = 1'b0; tick();
        tx_done_ack = 1'b1; tick();
        chk("full_idle", 32'({busy, full}), 32'b01);
        wr_en = 1'b1; wr_data = 8'hee; tick(); wr_en = 1'b0;
        chk("wfull_pop", 32'({overflow, 5'(level), tx_command_send, tx_data}),
            32'({1'b1, 5'd15, 1'b1, 8'h41}));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        wr_en = 1'b1; wr_data = 8'h77; tick();
        clr_flags = 1'b1; tick();
        chk("clr_vs_event", 32'(overflow), 32'd1);
        wr_en = 1'b0; tick(); clr_flags = 1'b0;
        chk("clr_after", 32'(overflow), 32'd0);

        // reset while waiting for done with 5 bytes queued
        do_reset();
        tx_done_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin wr_en = 1'b1; wr_data = 8'(8'h90 + i); tick(); end
        wr_en = 1'b0;
        chk("q5_level", 32'(level), 32'd5);
        tx_done_ack = 1'b0; tick();
        chk("q5_wait", 32'({busy, tx_command_send}), 32'b10);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst", 32'({tx_command_send, 5'(level), empty, busy, tx_data}),
            32'({1'b0, 5'd0, 1'b1, 1'b0, 8'h00}));

        // transmitter never drops done_ack
        tx_done_ack = 1'b1;
        wr_en = 1'b1; wr_data = 8'h5a; tick();
        wr_data = 8'ha5; tick(); wr_en = 1'b0;
        chk("stall_cmd0", 32'(tx_command_send), 32'd1);
`ifdef NEXI_UART_TX_FEEDER_TIMEOUT_EN
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_still_high", 32'(tx_command_send), 32'd1);
        tick();
        chk("to_fall", 32'({tx_command_send, err_timeout}), 32'b01);
        tick();
        chk("to_next", 32'({tx_command_send, tx_data}), 32'({1'b1, 8'ha5}));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
`else
        for (int i = 0; i < 40; i++) tick();
        chk("noto_high", 32'({tx_command_send, err_timeout, tx_data}), 32'({1'b1, 1'b0, 8'h5a}));
`endif

        // random traffic against the queue model
        do_reset();
        txm_en = 1'b1; txm_rand = 1'b1; txm_ack = 1'b1; txm_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            wr_en     = ($urandom_range(0, 99) < 45);
            wr_data   = 8'($urandom);
            clr_flags = ($urandom_range(0, 99) < 4);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; wr_en = 1'b0; clr_flags = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nexi_uart_tx_feeder.md
Name: nexi_uart_tx_feeder

Overview:
- Byte FIFO and handshake sequencer that sits directly upstream of nexi_uart_tx.
- Accepts bytes from a host-side write port, buffers them, and drives the command_send / data / done_ack handshake of nexi_uart_tx one byte at a time.
- Runs in the UART TX clock domain; its outputs connect straight to the transmitter.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- ADDR_W, 4, log2(DEPTH); must match DEPTH.
- TO_W, 16, timeout counter width; used only with the optional feature.
- TIMEOUT_CYCLES, 65535, cycles allowed per handshake phase before abort; must be below 2^TO_W. Used only with the optional feature.

Ports:
- clk_1x_bps  in  1  clock; same clock as nexi_uart_tx.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; one byte per cycle.
- wr_data  in  8  byte to enqueue.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  ADDR_W+1  current FIFO occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- clr_flags  in  1  clears overflow and err_timeout.
- busy  out  1  sequencer is not in S_IDLE.
- tx_command_send  out  1  to nexi_uart_tx command_send.
- tx_data  out  8  to nexi_uart_tx data.
- tx_done_ack  in  1  from nexi_uart_tx done_ack; high means idle/done.
- err_timeout  out  1  sticky handshake-timeout flag.

Behaviour:
- Reset (rst=1 at a rising edge):
  - FIFO emptied: empty=1, full=0, level=0.
  - overflow=0, err_timeout=0, busy=0.
  - tx_command_send=0, tx_data=8'h00.
  - State S_IDLE; timeout counter 0.
- Reset mid-transfer:
  - Aborts immediately; tx_command_send drops on the next edge.
  - The in-flight byte and all queued bytes are lost.
- FIFO:
  - Read/write pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH; level = wr_ptr - rd_ptr.
  - full, empty and level are registered and derived from the pointers.
  - A write with full=1 is dropped and sets overflow, even if a pop happens in the same cycle.
  - Simultaneous write (not full) and pop: both occur; level is unchanged.
- clr_flags: clears both sticky flags. If a new flag event occurs in the same cycle, the event wins and the flag stays 1.
- Sequencer, one-hot states S_IDLE, S_REQ, S_WAIT_DONE:
  - S_IDLE: if empty=0 and tx_done_ack=1, pop the head into tx_data, set tx_command_send=1, go to S_REQ. Otherwise hold.
  - S_REQ: if tx_done_ack=0 (transmitter accepted), set tx_command_send=0 and go to S_WAIT_DONE.
  - S_WAIT_DONE: if tx_done_ack=1, go to S_IDLE.
- tx_data is held stable from the pop until the next pop; it is never cleared except by reset.
- Latency:
  - A byte written at edge N into an empty FIFO with an idle sequencer produces tx_command_send=1 after edge N+1.
  - Back-to-back bytes have at least one cycle of tx_command_send=0 between requests (the S_IDLE cycle).
- tx_command_send is never high in S_WAIT_DONE or S_IDLE.
- busy=1 in S_REQ and S_WAIT_DONE.

Optional Feature:
- Macro: NEXI_UART_TX_FEEDER_TIMEOUT_EN.
- With the macro defined:
  - The counter clears on every state change and increments each cycle in S_REQ and S_WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: tx_command_send goes to 0, the state goes to S_IDLE, err_timeout is set, and the current byte is discarded.
- Without the macro:
  - No counter is built; the sequencer waits indefinitely.
  - err_timeout is constant 0.

Test Plan:
- Reset, then write 8'h33 at edge N with a responsive TX model that drops done_ack 2 cycles after command_send and raises it 10 cycles later -> tx_command_send=1 and tx_data=8'h33 after edge N+1; command_send=0 the cycle after done_ack=0; busy returns to 0; empty=1.
- Write 8'h33, 8'hcc, 8'h11 back-to-back -> three handshakes in order with tx_data 33, cc, 11; command_send low for at least 1 cycle between requests; level goes 3, 2, 1, 0.
- With DEPTH=16 and a stalled TX (done_ack held high but not dropping), write 18 bytes -> full=1 at level 16, overflow=1 (the fill-up byte may be popped into tx_data first, so 17 bytes can be accepted), remaining bytes dropped. Pulse clr_flags -> overflow=0.
- Assert rst for 1 cycle while in S_WAIT_DONE with 5 bytes queued -> next cycle: tx_command_send=0, level=0, empty=1, busy=0, tx_data=00.
- With the macro defined and TIMEOUT_CYCLES=20, TX never drops done_ack -> command_send falls after 20 cycles in S_REQ, err_timeout=1, and the next queued byte is then issued. Without the macro -> command_send stays high indefinitely and err_timeout=0.
- Write when full while a pop occurs in the same cycle -> write dropped, overflow=1, level decrements by 1.
